io_peripheral_responder: RTL

// Peripheral-side end of the core I/O port: consumes to_peripheral/_data/_valid commands from RISC_V_Core and

---
 rtl/io_peripheral_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/io_peripheral_responder.sv
// Peripheral end of the core I/O port: one response per accepted core command,
// plus RX (host->core) and TX (core->host) word FIFOs.
module io_peripheral_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_AW      = 3,
    parameter int RESP_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            to_peripheral,
    input  logic [DATA_WIDTH-1:0] to_peripheral_data,
    input  logic                  to_peripheral_valid,
    output logic [1:0]            from_peripheral,
    output logic [DATA_WIDTH-1:0] from_peripheral_data,
    output logic                  from_peripheral_valid,
    input  logic [DATA_WIDTH-1:0] host_rx_data,
    input  logic                  host_rx_valid,
    output logic                  host_rx_ready,
    output logic [DATA_WIDTH-1:0] host_tx_data,
    output logic                  host_tx_valid,
    input  logic                  host_tx_ready,
    output logic                  busy
);

    // state   | meaning
    // IDLE    | ready to accept a command
    // WAIT    | response latched, counting down the latency
    // RESP    | response goes out on the next edge
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] CMD_NOP    = 2'b00;
    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_READ   = 2'b10;
    localparam logic [1:0] CMD_STATUS = 2'b11;
    localparam logic [1:0] RSP_NONE   = 2'b00;
    localparam logic [1:0] RSP_ACK    = 2'b01;
    localparam logic [1:0] RSP_DATA   = 2'b10;
    localparam logic [1:0] RSP_ERR    = 2'b11;

    localparam int               DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [3:0]       LAT_LOAD   = 4'(RESP_LATENCY - 1);

    logic [1:0]            state;
    logic [3:0]            lat_cnt;
    logic                  overrun;
    logic [1:0]            resp_code;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [1:0]            resp_code_d;
    logic [DATA_WIDTH-1:0] resp_data_d;
    logic [DATA_WIDTH-1:0] status_word;

    logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
    logic [FIFO_AW-1:0]    rx_wptr, rx_rptr, tx_wptr, tx_rptr;
    logic [FIFO_AW:0]      rx_count, tx_count;
    logic                  rx_full, rx_empty, tx_full, tx_empty;
    logic                  rx_push, rx_pop, tx_push, tx_pop;
    logic                  cmd_seen, accept, drop;

    assign cmd_seen = to_peripheral_valid && (to_peripheral != CMD_NOP);
    assign accept   = cmd_seen && (state == ST_IDLE);
    assign drop     = cmd_seen && (state != ST_IDLE);

    assign rx_full  = (rx_count == FULL_COUNT);
    assign rx_empty = (rx_count == '0);
    assign tx_full  = (tx_count == FULL_COUNT);
    assign tx_empty = (tx_count == '0);

    assign rx_pop  = accept && (to_peripheral == CMD_READ) && !rx_empty;
    // A core pop frees a slot on the same edge, so a host push into a full RX FIFO still lands.
    assign rx_push = host_rx_valid && (!rx_full || rx_pop);
    assign tx_push = accept && (to_peripheral == CMD_WRITE) && !tx_full;
    assign tx_pop  = !tx_empty && host_tx_ready;

    assign host_rx_ready = !rx_full;
    assign host_tx_valid = !tx_empty;
    assign host_tx_data  = tx_empty ? '0 : tx_mem[tx_rptr];
    assign busy          = (state != ST_IDLE);

    assign status_word = DATA_WIDTH'({overrun, 13'b0, tx_full, rx_empty, 8'(tx_count), 8'(rx_count)});

    always_comb begin
        resp_code_d = RSP_ERR;
        resp_data_d = '0;
        case (to_peripheral)
            CMD_WRITE: if (!tx_full) begin
                resp_code_d = RSP_ACK;
                resp_data_d = to_peripheral_data;
            end
            CMD_READ: if (!rx_empty) begin
                resp_code_d = RSP_DATA;
                resp_data_d = rx_mem[rx_rptr];
            end
            CMD_STATUS: begin
                resp_code_d = RSP_DATA;
                resp_data_d = status_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rx_push) rx_mem[rx_wptr] <= host_rx_data;
        if (tx_push) tx_mem[tx_wptr] <= to_peripheral_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: ;
            endcase
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                 <= ST_IDLE;
            lat_cnt               <= '0;
            overrun               <= 1'b0;
            resp_code             <= RSP_NONE;
            resp_data             <= '0;
            from_peripheral       <= RSP_NONE;
            from_peripheral_data  <= '0;
            from_peripheral_valid <= 1'b0;
        end else begin
            from_peripheral_valid <= (state == ST_RESP);
            from_peripheral       <= (state == ST_RESP) ? resp_code : RSP_NONE;
            from_peripheral_data  <= (state == ST_RESP) ? resp_data : '0;

            if (drop)
                overrun <= 1'b1;
            else if (accept && (to_peripheral == CMD_STATUS))
                overrun <= 1'b0;

            case (state)
                ST_IDLE: if (accept) begin
                    resp_code <= resp_code_d;
                    resp_data <= resp_data_d;
                    lat_cnt   <= LAT_LOAD;
                    state     <= (RESP_LATENCY <= 1) ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt <= 4'd1) state <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
